uart_tx_engine: RTL and testbench
=================================

// Module: uart_tx_engine
// PURPOSE
//  Parametrised UART transmit engine: serialises words into start/data/parity/stop frames on tx_o.
//  Adds a bit-rate divider, optional parity, 1 or 2 stop bits and a one-entry holding buffer
//    for gap-free back-to-back frames.
//  Upstream uses a valid/ready handshake. tx_o drives the pad directly.
// PARAMETERS
//  DATA_WIDTH    `UART_DATA_WIDTH (8)  data bits per frame, LSB first; legal range 5..9
//  CLKS_PER_BIT  16                    clk_i cycles per bit; must be >= 2
//  STOP_BITS     1                     number of stop bits; 1 or 2
//  PARITY_EN     0                     1 = insert a parity bit after the data bits
//  PARITY_ODD    0                     0 = even parity, 1 = odd parity (ignored if PARITY_EN = 0)
// PORTS
//  clk_i       in   1           single clock
//  rst_ni      in   1           asynchronous, active-low reset
//  data_i      in   DATA_WIDTH  word to transmit
//  data_v_i    in   1           data_i valid
//  data_rdy_o  out  1           holding buffer empty; a word is accepted when data_v_i & data_rdy_o
//  tx_o        out  1           serial line, idles high; always a flop output (glitch-free)
//  bit_v_o     out  1           1-cycle pulse in the first cycle of each data bit on tx_o
//  busy_o      out  1           (state != IDLE) | hold_full
// BEHAVIOUR
//  Reset values (async, while rst_ni=0): tx_o=1, data_rdy_o=1, bit_v_o=0, busy_o=0.
//    hold_full=0, state=IDLE, all counters 0.
//  Handshake:
//    - data_rdy_o = ~hold_full only; no same-cycle pass-through.
//    - Accept at edge E: data_i is copied to hold and hold_full=1.
//    - data_v_i while data_rdy_o=0 is ignored; data_i need not be held.
//  Frame start:
//    - Trigger: in IDLE with hold_full=1, or at the last cycle of the final stop bit with hold_full=1.
//    - Action: shifter <= hold, hold_full <= 0, baud counter cleared.
//    - If the word was accepted at edge E while in IDLE: state=START and tx_o=0 from edge E+1.
//  FSM: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE, or -> START if hold_full.
//    - Each state lasts CLKS_PER_BIT cycles per bit.
//    - DATA lasts DATA_WIDTH bits; a bit counter 0..DATA_WIDTH-1 shifts the register right
//      at each bit tick.
//    - STOP lasts STOP_BITS bits.
//  Frame length = CLKS_PER_BIT*(1+DATA_WIDTH+PARITY_EN+STOP_BITS) cycles.
//    Back-to-back frames have zero idle cycles.
//  tx_o levels: START=0, DATA=shifter[0], PARITY=^data XOR PARITY_ODD, STOP/IDLE=1.
//  Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps.
//    Bit tick at terminal count. Synchronously cleared at frame start.
//  Parity is computed from the word as loaded into the shifter (captured at load, not from the shifting value).
//  A new accept during any frame state only fills hold; the current frame is never disturbed.
//  Reset mid-frame: tx_o returns to 1 immediately. The frame and any held word are discarded.
//    The next frame starts cleanly after release.
//  Illegal parameters (CLKS_PER_BIT<2, STOP_BITS not 1/2, DATA_WIDTH out of range):
//    elaboration-time error from a generate check.
// STRUCTURE
//  uart.vh: `UART_DATA_WIDTH default; state encodings `UART_ST_IDLE/START/DATA/PARITY/STOP (3 bits).
//  Sub-module uart_baud_gen (CLKS_PER_BIT): inputs clk_i, rst_ni, clr_i; output tick_o.
//    Reused later by the receive path.
//  Top: holding register, shifter + bit counter, FSM, registered tx_o/bit_v_o.
// TESTING  (DATA_WIDTH=8, CLKS_PER_BIT=4 unless noted)
//  1. Reset, no stimulus -> tx_o=1, data_rdy_o=1, busy_o=0, bit_v_o=0 for 100 cycles.
//  2. Send 0xA5, no parity, 1 stop -> tx_o = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
//     Frame is 40 cycles; 8 bit_v_o pulses, 4 cycles apart.
//  3. Send 0x00, then 0xFF accepted mid-frame -> second start bit directly follows first stop bit.
//     Zero gap; data_rdy_o low from second accept until second load.
//  4. PARITY_EN=1, send 0x07 -> even: parity bit 1; PARITY_ODD=1: parity bit 0.
//     STOP_BITS=2 -> stop high 8 cycles; frame 48 cycles.
//  5. rst_ni low during data bit 3 -> tx_o=1 the same cycle. After release: data_rdy_o=1.
//     Next frame 0x3C is bit-exact.
//  6. data_v_i held high for 5 frames with a random data_i -> exactly one frame per handshake.
//     Scoreboard matches the sampled words in order; nothing dropped or duplicated.

Source files
------------

// File: rtl/uart_tx_engine_pkg.sv
// Shared types and helpers for the UART transmit path.
// The state encodings and counter-width helper are also reused by the receive path.
package uart_tx_engine_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // A counter that must hold 0..n-1 needs at least one bit, even when n is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit uart_params_legal(input int data_width, input int clks_per_bit,
                                           input int stop_bits, input int parity_en,
                                           input int parity_odd);
    return (data_width >= 5) && (data_width <= 9) && (clks_per_bit >= 2) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           ((parity_en == 0) || (parity_en == 1)) &&
           ((parity_odd == 0) || (parity_odd == 1));
  endfunction

endpackage

// File: rtl/uart_tx_engine_baud_gen.sv
// Bit-rate divider: free-running 0..CLKS_PER_BIT-1 counter with a terminal-count tick.
// Shared by the transmit and receive paths; clr_i realigns the bit grid to a frame start.
module uart_baud_gen
  import uart_tx_engine_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_baud_gen: CLKS_PER_BIT must be >= 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || (cnt_q == TERM)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == TERM);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: one-word holding buffer feeding a start/data/parity/stop serialiser.
// A word waiting in the holding buffer is launched on the final stop tick, so frames abut.
module uart_tx_engine
  import uart_tx_engine_pkg::*;
#(
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_v_i,
  output logic                  data_rdy_o,
  output logic                  tx_o,
  output logic                  bit_v_o,
  output logic                  busy_o
);

  localparam int BW = cnt_width(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic          ODD_SENSE = 1'(PARITY_ODD);

  if (!uart_params_legal(DATA_WIDTH, CLKS_PER_BIT, STOP_BITS, PARITY_EN, PARITY_ODD))
  begin : g_bad_params
    $error("uart_tx_engine: illegal DATA_WIDTH/CLKS_PER_BIT/STOP_BITS/PARITY parameters");
  end

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  tx_q, tx_d;
  logic                  bit_v_q, bit_v_d;

  logic tick;
  logic accept;
  logic load;
  logic last_data;
  logic last_stop;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (load),
    .tick_o(tick)
  );

  assign accept    = data_v_i & ~hold_full_q;
  assign last_data = (bit_cnt_q == LAST_BIT);
  assign last_stop = (stop_cnt_q == LAST_STOP);
  assign load      = hold_full_q &
                     ((state_q == ST_IDLE) || ((state_q == ST_STOP) && tick && last_stop));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hold_full_q) state_d = ST_START;
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick && last_data) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (tick && last_stop) state_d = hold_full_q ? ST_START : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Accept and load are mutually exclusive: one needs the buffer empty, the other full.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    if (accept) begin
      hold_d      = data_i;
      hold_full_d = 1'b1;
    end
    if (load) begin
      shift_d     = hold_q;
      parity_d    = (^hold_q) ^ ODD_SENSE;
      hold_full_d = 1'b0;
      bit_cnt_d   = '0;
      stop_cnt_d  = 1'b0;
    end else if (tick) begin
      unique case (state_q)
        ST_DATA: begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = last_data ? '0 : bit_cnt_q + BW'(1);
        end
        ST_STOP: begin
          stop_cnt_d = last_stop ? 1'b0 : stop_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Line level and bit strobe are decoded from the next state so both leave a flop together.
  always_comb begin
    tx_d    = 1'b1;
    bit_v_d = 1'b0;
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_q;
      default:   tx_d = 1'b1;
    endcase
    if ((state_d == ST_DATA) && tick && !load &&
        ((state_q == ST_START) || ((state_q == ST_DATA) && !last_data))) begin
      bit_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      tx_q        <= 1'b1;
      bit_v_q     <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      tx_q        <= tx_d;
      bit_v_q     <= bit_v_d;
    end
  end

  assign data_rdy_o = ~hold_full_q;
  assign tx_o       = tx_q;
  assign bit_v_o    = bit_v_q;
  assign busy_o     = (state_q != ST_IDLE) | hold_full_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: three instances cover 8N1, 8E2 and 8O1 at 4 clocks/bit.
// Frames are compared cycle by cycle against hand-computed bit patterns.
module tb_uart_tx_engine;

  typedef struct {
    int          sel;
    logic [7:0]  data;
    int          nbits;
    logic [11:0] bits;
    string       name;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] dataR [3];
  logic       vR    [3];
  logic       txW   [3];
  logic       rdyW  [3];
  logic       bitvW [3];
  logic       busyW [3];

  int testsRun = 0;
  int failures = 0;
  vec_t vecs [6];

  uart_tx_engine #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(dataR[0]), .data_v_i(vR[0]),
    .data_rdy_o(rdyW[0]), .tx_o(txW[0]), .bit_v_o(bitvW[0]), .busy_o(busyW[0])
  );

  uart_tx_engine #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(dataR[1]), .data_v_i(vR[1]),
    .data_rdy_o(rdyW[1]), .tx_o(txW[1]), .bit_v_o(bitvW[1]), .busy_o(busyW[1])
  );

  uart_tx_engine #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)
  ) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(dataR[2]), .data_v_i(vR[2]),
    .data_rdy_o(rdyW[2]), .tx_o(txW[2]), .bit_v_o(bitvW[2]), .busy_o(busyW[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one word for a single accepting edge, then scramble data_i.
  task automatic applyStimulus(input int s, input logic [7:0] d);
    @(negedge clk);
    dataR[s] = d;
    vR[s]    = 1'b1;
    @(posedge clk);
    #1;
    vR[s]    = 1'b0;
    dataR[s] = 8'($urandom);
    checkOutput($sformatf("dut%0d_rdy_after_accept", s), 32'(rdyW[s]), 32'(1'b0));
  endtask

  task automatic runVector(input int i);
    vec_t v;
    int   s;
    logic expBitv;
    v = vecs[i];
    s = v.sel;
    checkOutput({v.name, "_rdy_before"}, 32'(rdyW[s]), 32'(1'b1));
    applyStimulus(s, v.data);
    for (int b = 0; b < v.nbits; b++) begin
      for (int c = 0; c < 4; c++) begin
        @(posedge clk);
        #1;
        expBitv = (c == 0) && (b >= 1) && (b <= 8);
        checkOutput($sformatf("%s_bit%0d_cyc%0d_tx_bitv_busy", v.name, b, c),
                    32'({txW[s], bitvW[s], busyW[s]}), 32'({v.bits[b], expBitv, 1'b1}));
      end
    end
    @(posedge clk);
    #1;
    checkOutput({v.name, "_idle_tx_bitv_busy_rdy"},
                32'({txW[s], bitvW[s], busyW[s], rdyW[s]}), 32'(4'b1001));
  endtask

  initial begin
    logic [7:0] sb [$];
    logic [7:0] rxWord;
    logic [7:0] expWord;
    logic       expTx;
    logic       expRdy;
    int         acc;
    int         got;
    int         rxCnt;
    int         cyc;
    int         b;

    vecs[0] = '{0, 8'hA5, 10, 12'h34A, "a5_8n1"};
    vecs[1] = '{1, 8'h07, 12, 12'hE0E, "07_8e2"};
    vecs[2] = '{2, 8'h07, 11, 12'h40E, "07_8o1"};
    vecs[3] = '{1, 8'hFF, 12, 12'hDFE, "ff_8e2"};
    vecs[4] = '{2, 8'h5A, 11, 12'h6B4, "5a_8o1"};
    vecs[5] = '{0, 8'h3C, 10, 12'h278, "3c_after_reset"};

    for (int s = 0; s < 3; s++) begin
      dataR[s] = 8'h00;
      vR[s]    = 1'b0;
    end
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("in_reset_tx_rdy_busy_bitv",
                32'({txW[0], rdyW[0], busyW[0], bitvW[0], txW[1], rdyW[1], busyW[1], bitvW[1],
                     txW[2], rdyW[2], busyW[2], bitvW[2]}), 32'(12'hCCC));
    @(negedge clk);
    rst_n = 1'b1;

    // Quiet line after reset.
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("idle_cyc%0d", i),
                  32'({txW[0], rdyW[0], busyW[0], bitvW[0], txW[1], rdyW[1], busyW[1], bitvW[1],
                       txW[2], rdyW[2], busyW[2], bitvW[2]}), 32'(12'hCCC));
    end

    for (int i = 0; i < 5; i++) begin
      runVector(i);
    end

    // 0x00 then 0xFF accepted mid-frame: second start bit must follow the stop bit directly.
    applyStimulus(0, 8'h00);
    for (int k = 1; k <= 84; k++) begin
      if (k == 9) begin
        @(negedge clk);
        dataR[0] = 8'hFF;
        vR[0]    = 1'b1;
      end
      @(posedge clk);
      #1;
      if (k == 9) begin
        vR[0]    = 1'b0;
        dataR[0] = 8'($urandom);
      end
      b = (k - 1) / 4;
      if (b < 10)      expTx = (b == 9);
      else if (b < 20) expTx = (b != 10);
      else             expTx = 1'b1;
      expRdy = !((k >= 9) && (k <= 40));
      checkOutput($sformatf("b2b_cyc%0d_tx_rdy", k),
                  32'({txW[0], rdyW[0]}), 32'({expTx, expRdy}));
    end
    checkOutput("b2b_end_busy", 32'(busyW[0]), 32'(1'b0));

    // Reset in the middle of data bit 3 of 0xA5.
    applyStimulus(0, 8'hA5);
    repeat (18) @(posedge clk);
    #1;
    checkOutput("pre_reset_tx_data_bit3", 32'(txW[0]), 32'(1'b0));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_frame_reset_tx_bitv_busy_rdy",
                32'({txW[0], bitvW[0], busyW[0], rdyW[0]}), 32'(4'b1001));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_release_tx_bitv_busy_rdy",
                32'({txW[0], bitvW[0], busyW[0], rdyW[0]}), 32'(4'b1001));
    runVector(5);

    // data_v_i held high with fresh random data every cycle for five handshakes.
    acc   = 0;
    got   = 0;
    rxCnt = -1;
    cyc   = 0;
    rxWord = 8'h00;
    while ((got < 5) && (cyc < 600)) begin
      @(negedge clk);
      if (acc < 5) begin
        dataR[0] = 8'($urandom);
        vR[0]    = 1'b1;
      end else begin
        vR[0] = 1'b0;
      end
      if (vR[0] && rdyW[0]) begin
        sb.push_back(dataR[0]);
        acc++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rxCnt < 0) begin
        if (txW[0] == 1'b0) rxCnt = 0;
      end else begin
        rxCnt++;
      end
      if (rxCnt >= 5 && rxCnt <= 33 && ((rxCnt - 5) % 4) == 0) begin
        rxWord[(rxCnt - 5) / 4] = txW[0];
      end
      if (rxCnt == 37) begin
        checkOutput($sformatf("stream_frame%0d_stop", got), 32'(txW[0]), 32'(1'b1));
        expWord = (sb.size() > 0) ? sb.pop_front() : ~rxWord;
        checkOutput($sformatf("stream_frame%0d_word", got), 32'(rxWord), 32'(expWord));
        got++;
        rxCnt = -1;
      end
    end
    vR[0] = 1'b0;
    checkOutput("stream_frames_received", 32'(got), 32'(5));
    checkOutput("stream_handshakes", 32'(acc), 32'(5));
    checkOutput("stream_scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
